ex_mem_latch: RTL and testbench
===============================

// Module: ex_mem_latch
// PURPOSE
//  EX->MEM pipeline stage directly downstream of the 16-bit ALU. Captures ALU result,
//  flags and control fields. Holds the architectural N/Z/V flag register.
//  Decouples EX from MEM with a 2-entry skid buffer (valid/ready on both sides).
//  Squashes the write-back of overflowing add/sub ops and raises an overflow trap.
// PARAMETERS
//  DATA_W  16  datapath width (ALU result, store data, pc)
//  REG_W   3   destination register index width
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous, active-high reset
//  in_valid       in   1       EX presents an op this cycle
//  in_ready       out  1       latch can accept; registered, = ~skid_valid
//  in_alu_out     in   DATA_W  ALU result
//  in_neg/in_zero/in_ovf in 1  ALU flag outputs
//  in_codop       in   4       ALU opcode of this op
//  in_rd          in   REG_W   destination register
//  in_we          in   1       register write-enable
//  in_mem_rd      in   1       load
//  in_mem_wr      in   1       store
//  in_store_data  in   DATA_W  store data
//  in_pc          in   DATA_W  pc of this op
//  flush          in   1       kill all held and incoming ops
//  out_valid      out  1       MEM-side entry valid
//  out_ready      in   1       MEM consumes the entry when out_valid&out_ready
//  out_alu_out/out_rd/out_we/out_mem_rd/out_mem_wr/out_store_data  out  fields of head entry
//  flags          out  3       {N,Z,V} architectural flags
//  ovf_trap       out  1       one-cycle pulse; overflow op accepted last cycle
//  epc            out  DATA_W  pc of the most recent trapping op
// BEHAVIOUR
//  - Reset (rst=1 at edge): main_valid=skid_valid=0, so out_valid=0 and in_ready=1 next.
//    flags=0, ovf_trap=0, epc=0. Data fields are don't-care while invalid.
//  - Accept = in_valid & in_ready & ~flush. Drain = out_valid & out_ready.
//  - Main register drives out_*. Skid register is used only while main is stalled.
//    * main empty or draining: accepted op (or skid content, which takes priority) loads main.
//    * main full, not draining, accept: op goes to skid. in_ready=0 from the next cycle.
//    * skid full & drain: skid->main, skid empties. Nothing is lost or reordered (FIFO).
//  - Latency: accepted op is visible on out_* the cycle after acceptance when main is free.
//    Throughput is 1 op/cycle when out_ready=1 continuously.
//  - Flags: on accept with codop in 0..10, flags <= {in_neg,in_zero,in_ovf} the next cycle.
//    For codop 11..15 flags are held. Flags update at acceptance, not at drain.
//  - Overflow squash: accepted op with in_ovf=1 and codop in {0,1,9,10} is stored with we=0.
//    mem_rd/mem_wr are forced 0. Same edge: epc<=in_pc, ovf_trap<=1 for exactly one cycle.
//  - flush: at the edge, main_valid=skid_valid=0. Incoming op is dropped, flags not updated.
//    No trap is raised. flush overrides accept, drain and skid moves in the same cycle.
//  - rst overrides flush. Reset mid-stall discards both entries.
//  - Valid never de-asserts without drain, flush or rst. out_* is stable while out_valid&~out_ready.
// CONFIGURATION
//  EXM_OVF_TRAP_EN defined: overflow squash, ovf_trap and epc behave as above.
//  EXM_OVF_TRAP_EN undefined: no squash (we/mem_* pass through). ovf_trap tied 0, epc tied 0.
//  V flag still updates from in_ovf in both builds.
// TESTING
//  1 Reset: rst=1 two cycles -> out_valid=0, in_ready=1, flags=3'b000, ovf_trap=0, epc=0.
//  2 Stream: out_ready=1, ops add rd=2 res=16'h0005, sub rd=3 res=16'hFFFE ->
//    out next cycle each; flags 3'b000 then 3'b100.
//  3 Backpressure: out_ready=0, accept A,B -> in_ready=0 after B, out shows A.
//    out_ready=1 -> A then B, in_ready back to 1.
//  4 Overflow: codop=0, in_ovf=1, in_we=1, in_pc=16'h0040 -> out_we=0, ovf_trap=1 one cycle.
//    epc=16'h0040, flags[0]=1. Undefined macro: out_we=1, ovf_trap=0.
//  5 Flush: main+skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1.
//    flags unchanged, no trap.
//  6 Flag hold: accept codop=12 with in_zero=1 -> flags unchanged. Op still passes to out.

Source files
------------

// File: rtl/ex_mem_latch.sv
// EX->MEM pipeline latch: 2-entry skid buffer, N/Z/V flag register, optional overflow squash/trap.
// Define EXM_OVF_TRAP_EN to enable overflow squash, ovf_trap and epc.
module ex_mem_latch #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic              in_neg,
  input  logic              in_zero,
  input  logic              in_ovf,
  input  logic [3:0]        in_codop,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_we,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_we,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic [DATA_W-1:0] out_store_data,
  output logic [2:0]        flags,
  output logic              ovf_trap,
  output logic [DATA_W-1:0] epc
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic [REG_W-1:0]  rd;
    logic              we;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] store_data;
  } entry_t;

  entry_t main_q, skid_q, in_entry;
  logic   main_valid_q, skid_valid_q;
  logic   [2:0] flags_q;
  logic   accept, drain, main_free, flag_upd, squash;

  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = main_valid_q & out_ready;
  assign main_free = ~main_valid_q | drain;
  assign flag_upd  = accept & (in_codop <= 4'd10);

  // Only add/sub style opcodes can overflow into a squashed write-back.
`ifdef EXM_OVF_TRAP_EN
  assign squash = accept & in_ovf &
                  ((in_codop == 4'd0) | (in_codop == 4'd1) |
                   (in_codop == 4'd9) | (in_codop == 4'd10));
`else
  assign squash = 1'b0;
`endif

  always_comb begin
    in_entry.alu_out    = in_alu_out;
    in_entry.rd         = in_rd;
    in_entry.we         = in_we & ~squash;
    in_entry.mem_rd     = in_mem_rd & ~squash;
    in_entry.mem_wr     = in_mem_wr & ~squash;
    in_entry.store_data = in_store_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      flags_q      <= 3'b000;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      if (main_free) begin
        // Skid content is older than anything incoming, so it refills main first.
        if (skid_valid_q) begin
          main_q       <= skid_q;
          main_valid_q <= 1'b1;
          skid_valid_q <= 1'b0;
        end else if (accept) begin
          main_q       <= in_entry;
          main_valid_q <= 1'b1;
        end else begin
          main_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_q       <= in_entry;
        skid_valid_q <= 1'b1;
      end
      if (flag_upd) begin
        flags_q <= {in_neg, in_zero, in_ovf};
      end
    end
  end

`ifdef EXM_OVF_TRAP_EN
  logic              ovf_trap_q;
  logic [DATA_W-1:0] epc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_trap_q <= 1'b0;
      epc_q      <= '0;
    end else begin
      ovf_trap_q <= squash;
      if (squash) begin
        epc_q <= in_pc;
      end
    end
  end

  assign ovf_trap = ovf_trap_q;
  assign epc      = epc_q;
`else
  logic unused_pc;
  assign unused_pc = ^in_pc;
  assign ovf_trap  = 1'b0;
  assign epc       = '0;
`endif

  assign in_ready       = ~skid_valid_q;
  assign out_valid      = main_valid_q;
  assign out_alu_out    = main_q.alu_out;
  assign out_rd         = main_q.rd;
  assign out_we         = main_q.we;
  assign out_mem_rd     = main_q.mem_rd;
  assign out_mem_wr     = main_q.mem_wr;
  assign out_store_data = main_q.store_data;
  assign flags          = flags_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed-vector bench for ex_mem_latch; expectations follow EXM_OVF_TRAP_EN when defined.
module tb_ex_mem_latch;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 3;

`ifdef EXM_OVF_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu_out;
  logic              in_neg, in_zero, in_ovf;
  logic [3:0]        in_codop;
  logic [REG_W-1:0]  in_rd;
  logic              in_we, in_mem_rd, in_mem_wr;
  logic [DATA_W-1:0] in_store_data;
  logic [DATA_W-1:0] in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu_out;
  logic [REG_W-1:0]  out_rd;
  logic              out_we, out_mem_rd, out_mem_wr;
  logic [DATA_W-1:0] out_store_data;
  logic [2:0]        flags;
  logic              ovf_trap;
  logic [DATA_W-1:0] epc;

  int n_vec = 0;
  int n_err = 0;

  ex_mem_latch #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_out    (in_alu_out),
    .in_neg        (in_neg),
    .in_zero       (in_zero),
    .in_ovf        (in_ovf),
    .in_codop      (in_codop),
    .in_rd         (in_rd),
    .in_we         (in_we),
    .in_mem_rd     (in_mem_rd),
    .in_mem_wr     (in_mem_wr),
    .in_store_data (in_store_data),
    .in_pc         (in_pc),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_alu_out   (out_alu_out),
    .out_rd        (out_rd),
    .out_we        (out_we),
    .out_mem_rd    (out_mem_rd),
    .out_mem_wr    (out_mem_wr),
    .out_store_data(out_store_data),
    .flags         (flags),
    .ovf_trap      (ovf_trap),
    .epc           (epc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle #1 after it; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] codop, input logic [REG_W-1:0] rd,
                          input logic [DATA_W-1:0] res, input logic n, input logic z,
                          input logic v, input logic we, input logic mrd, input logic mwr,
                          input logic [DATA_W-1:0] pc);
    in_valid      = 1'b1;
    in_codop      = codop;
    in_rd         = rd;
    in_alu_out    = res;
    in_neg        = n;
    in_zero       = z;
    in_ovf        = v;
    in_we         = we;
    in_mem_rd     = mrd;
    in_mem_wr     = mwr;
    in_store_data = res ^ 16'hA5A5;
    in_pc         = pc;
  endtask

  logic [DATA_W-1:0] exp_epc;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive_op(4'd0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    in_valid = 1'b0;

    // Reset
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_flags",     32'(flags),     32'd0);
    check("rst_trap",      32'(ovf_trap),  32'd0);
    check("rst_epc",       32'(epc),       32'd0);

    // Streaming
    out_ready = 1'b1;
    drive_op(4'd0, 3'd2, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010);
    step();
    check("s1_valid", 32'(out_valid),   32'd1);
    check("s1_data",  32'(out_alu_out), 32'h0005);
    check("s1_rd",    32'(out_rd),      32'd2);
    check("s1_sdata", 32'(out_store_data), 32'h0005 ^ 32'hA5A5);
    check("s1_flags", 32'(flags),       32'b000);
    drive_op(4'd1, 3'd3, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0012);
    step();
    check("s2_valid", 32'(out_valid),   32'd1);
    check("s2_data",  32'(out_alu_out), 32'hFFFE);
    check("s2_rd",    32'(out_rd),      32'd3);
    check("s2_flags", 32'(flags),       32'b100);
    in_valid = 1'b0;
    step();
    check("s_drained", 32'(out_valid), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    drive_op(4'd2, 3'd4, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0020);
    step();
    check("bp_a_out",   32'(out_alu_out), 32'h000A);
    check("bp_a_ready", 32'(in_ready),    32'd1);
    drive_op(4'd2, 3'd5, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0022);
    step();
    check("bp_b_ready", 32'(in_ready),    32'd0);
    check("bp_hold_a",  32'(out_alu_out), 32'h000A);
    drive_op(4'd2, 3'd6, 16'h000C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0024);
    step();
    check("bp_stable",  32'(out_alu_out), 32'h000A);
    check("bp_rd_a",    32'(out_rd),      32'd4);
    check("bp_noacc",   32'(flags),       32'b000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_b_out",   32'(out_alu_out), 32'h000B);
    check("bp_b_rd",    32'(out_rd),      32'd5);
    check("bp_b_valid", 32'(out_valid),   32'd1);
    check("bp_ready1",  32'(in_ready),    32'd1);
    step();
    check("bp_empty",   32'(out_valid),   32'd0);

    // Overflow
    drive_op(4'd0, 3'd1, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0040);
    step();
    exp_epc = TrapEn ? 16'h0040 : 16'h0000;
    check("ov_valid", 32'(out_valid),  32'd1);
    check("ov_we",    32'(out_we),     TrapEn ? 32'd0 : 32'd1);
    check("ov_mwr",   32'(out_mem_wr), TrapEn ? 32'd0 : 32'd1);
    check("ov_trap",  32'(ovf_trap),   TrapEn ? 32'd1 : 32'd0);
    check("ov_epc",   32'(epc),        32'(exp_epc));
    check("ov_flags", 32'(flags),      32'b101);
    in_valid = 1'b0;
    step();
    check("ov_trap_end", 32'(ovf_trap), 32'd0);
    check("ov_epc_hold", 32'(epc),      32'(exp_epc));

    // Flush with main and skid full
    out_ready = 1'b0;
    drive_op(4'd0, 3'd1, 16'h0101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050);
    step();
    drive_op(4'd3, 3'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0052);
    step();
    check("fl_full",  32'(in_ready), 32'd0);
    check("fl_flags0", 32'(flags),   32'b010);
    drive_op(4'd0, 3'd3, 16'h7777, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0060);
    flush = 1'b1;
    step();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready),  32'd1);
    check("fl_flags", 32'(flags),     32'b010);
    check("fl_trap",  32'(ovf_trap),  32'd0);
    // in_ready is now 1: incoming overflow op must still be dropped
    step();
    check("fl2_valid", 32'(out_valid), 32'd0);
    check("fl2_flags", 32'(flags),     32'b010);
    check("fl2_trap",  32'(ovf_trap),  32'd0);
    check("fl2_epc",   32'(epc),       32'(exp_epc));
    flush = 1'b0;

    // Flag hold on codop 12
    out_ready = 1'b1;
    drive_op(4'd12, 3'd6, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0070);
    step();
    check("fh_flags", 32'(flags),       32'b010);
    check("fh_valid", 32'(out_valid),   32'd1);
    check("fh_data",  32'(out_alu_out), 32'h1234);
    check("fh_we",    32'(out_we),      32'd1);
    check("fh_trap",  32'(ovf_trap),    32'd0);

    // Reset mid-stall discards both entries
    out_ready = 1'b0;
    drive_op(4'd4, 3'd1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0080);
    step();
    step();
    check("rs_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_ready", 32'(in_ready),  32'd1);
    check("rs_flags", 32'(flags),     32'd0);
    check("rs_epc",   32'(epc),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
